// File: rtl/cpu_fsm_if.sv
// Handshake and status bundle between the CPU sequencer and its memory/decoder side.
// CNT_W must match the CNT_W of the cpu_fsm instance the bundle connects to.
interface cpu_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic             waitrequest_i;
    logic [31:0]      pc_next_i;
    logic [1:0]       state_o;
    logic             active_o;
    logic             stall_o;
    logic [CNT_W-1:0] retired_o;
    logic [CNT_W-1:0] stall_cycles_o;

    // Sequencer side: consumes memory status, produces state and counters
    modport slave (
        input  waitrequest_i,
        input  pc_next_i,
        output state_o,
        output active_o,
        output stall_o,
        output retired_o,
        output stall_cycles_o
    );

    // Environment side: drives memory status, observes the sequencer
    modport master (
        output waitrequest_i,
        output pc_next_i,
        input  state_o,
        input  active_o,
        input  stall_o,
        input  retired_o,
        input  stall_cycles_o
    );
endinterface

// File: rtl/cpu_fsm.sv
// Multi-cycle CPU sequencer: FETCH -> EXEC1 -> EXEC2, each step held while memory
// asserts waitrequest; halts when the retiring instruction's next PC equals HALT_ADDR.
// Optional performance counters (retired instructions, stall cycles) are built only
// when CPU_FSM_PERF_EN is defined; otherwise both counter outputs are tied to zero.
module cpu_fsm #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic      clk,
    input  logic      reset,
    cpu_fsm_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC1  = 2'd1,
        ST_EXEC2  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   active_q, active_d;
    logic   stall_c;

    // A cycle is stalled whenever memory holds us off, except once halted
    assign stall_c = bus.waitrequest_i && (state_q != ST_HALTED);

    // State and activity registers; reset restarts at FETCH without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            active_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    // Next-state logic; pc_next_i only matters on an unstalled EXEC2 exit
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (!bus.waitrequest_i) state_d = ST_EXEC1;
            ST_EXEC1:  if (!bus.waitrequest_i) state_d = ST_EXEC2;
            ST_EXEC2: begin
                if (!bus.waitrequest_i) begin
                    state_d = (bus.pc_next_i == HALT_ADDR) ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
        active_d = (state_d != ST_HALTED);
    end

    assign bus.state_o  = state_q;
    assign bus.active_o = active_q;
    assign bus.stall_o  = stall_c;

`ifdef CPU_FSM_PERF_EN
    logic             retire_c;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Retire happens on the unstalled edge that leaves EXEC2, halting one included
    assign retire_c = (state_q == ST_EXEC2) && !bus.waitrequest_i;

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (retire_c && (retired_q != '1)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.retired_o      = retired_q;
    assign bus.stall_cycles_o = stall_cnt_q;
`else
    assign bus.retired_o      = CNT_W'(0);
    assign bus.stall_cycles_o = CNT_W'(0);
`endif

endmodule
